// File: rtl/ram_arbiter_2p_if.sv
// Requester-side bundle for ram_arbiter_2p: one access request, its grant,
// and the read-data return path for a single client port.
interface ram_arbiter_2p_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/ram_arbiter_2p.sv
// Two-port arbiter serialising read/write accesses onto a single-port 16x8 RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module ram_arbiter_2p #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    ram_arbiter_2p_if.slave port0,
    ram_arbiter_2p_if.slave port1,
    output logic            busy,
    output logic            ram_wen,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RDONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          pick;
    logic          winner;
    logic          we_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic          last_grant;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_nxt = state;
`ifdef RAM_ARB_FIXED_PRIO_EN
        pick = !port0.req;
`else
        pick = (port0.req && port1.req) ? !last_grant : !port0.req;
`endif
        case (state)
            IDLE:    if (port0.req || port1.req) state_nxt = ACCESS;
            ACCESS:  state_nxt = we_q ? IDLE : RWAIT;
            RWAIT:   state_nxt = RDONE;
            RDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner   <= 1'b0;
            we_q     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            // RAM controls are captured only when a request is accepted and hold otherwise.
            if (state == IDLE && (port0.req || port1.req)) begin
                winner   <= pick;
                we_q     <= pick ? port1.we    : port0.we;
                ram_addr <= pick ? port1.addr  : port0.addr;
                ram_din  <= pick ? port1.wdata : port0.wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
                last_grant <= pick;
`endif
            end
            if (state == RWAIT) begin
                if (winner) rdata1_q <= ram_dout;
                else        rdata0_q <= ram_dout;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign ram_wen      = (state == ACCESS) && we_q;
    assign port0.gnt    = (state == ACCESS) && !winner;
    assign port1.gnt    = (state == ACCESS) &&  winner;
    assign port0.rvalid = (state == RDONE)  && !winner;
    assign port1.rvalid = (state == RDONE)  &&  winner;
    assign port0.rdata  = rdata0_q;
    assign port1.rdata  = rdata1_q;
endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: directed table, reset and arbitration
// sequences, then random traffic against an array-based memory/arbitration model.
module tb_ram_arbiter_2p;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          busy;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_arbiter_2p_if #(.AW(AW), .DW(DW)) if0 ();
    ram_arbiter_2p_if #(.AW(AW), .DW(DW)) if1 ();

    ram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .port0   (if0),
        .port1   (if1),
        .busy    (busy),
        .ram_wen (ram_wen),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM stand-in: synchronous write, registered read one clock after the address edge.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge.
    int n_gnt0 = 0, n_gnt1 = 0, n_rv0 = 0, n_rv1 = 0, n_wen = 0;
    int n_both_gnt = 0, n_both_rv = 0;
    int idle_run = 0, gap_cnt = 0, gap_bad = 0;
    always @(negedge clk) begin
        if (if0.gnt) n_gnt0 <= n_gnt0 + 1;
        if (if1.gnt) n_gnt1 <= n_gnt1 + 1;
        if (if0.rvalid) n_rv0 <= n_rv0 + 1;
        if (if1.rvalid) n_rv1 <= n_rv1 + 1;
        if (ram_wen) n_wen <= n_wen + 1;
        if (if0.gnt && if1.gnt) n_both_gnt <= n_both_gnt + 1;
        if (if0.rvalid && if1.rvalid) n_both_rv <= n_both_rv + 1;
        if (!busy) idle_run <= idle_run + 1;
        else begin
            if (idle_run != 0) begin
                gap_cnt <= gap_cnt + 1;
                if (idle_run != 1) gap_bad <= gap_bad + 1;
            end
            idle_run <= 0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: memory contents and most recent winner.
    logic [DW-1:0] exp_mem [16];
    int            model_last = 1;

    int            g_cyc [2];
    int            r_cyc [2];
    logic [DW-1:0] r_dat [2];
    int            first_gnt;

    // Issue one op on each enabled port; each port holds req until its own gnt.
    task automatic run_ops(input bit en0, input op_t o0, input bit en1, input op_t o1);
        bit pend_g [2];
        bit pend_r [2];
        int n;
        pend_g[0] = en0; pend_g[1] = en1;
        pend_r[0] = 1'b0; pend_r[1] = 1'b0;
        first_gnt = -1;
        for (int i = 0; i < 2; i++) begin
            g_cyc[i] = -1; r_cyc[i] = -1; r_dat[i] = '0;
        end
        if0.req = en0; if0.we = o0.we; if0.addr = o0.addr; if0.wdata = o0.data;
        if1.req = en1; if1.we = o1.we; if1.addr = o1.addr; if1.wdata = o1.data;
        n = 0;
        while ((pend_g[0] || pend_g[1] || pend_r[0] || pend_r[1]) && n < 40) begin
            @(negedge clk);
            n++;
            if (pend_g[0] && if0.gnt) begin
                pend_g[0] = 1'b0; if0.req = 1'b0; g_cyc[0] = cyc; pend_r[0] = !o0.we;
                if (first_gnt < 0) first_gnt = 0;
            end
            if (pend_g[1] && if1.gnt) begin
                pend_g[1] = 1'b0; if1.req = 1'b0; g_cyc[1] = cyc; pend_r[1] = !o1.we;
                if (first_gnt < 0) first_gnt = 1;
            end
            if (pend_r[0] && if0.rvalid) begin
                pend_r[0] = 1'b0; r_cyc[0] = cyc; r_dat[0] = if0.rdata;
            end
            if (pend_r[1] && if1.rvalid) begin
                pend_r[1] = 1'b0; r_cyc[1] = cyc; r_dat[1] = if1.rdata;
            end
        end
        if0.req = 1'b0;
        if1.req = 1'b0;
        check("access completes within budget",
              32'(pend_g[0] || pend_g[1] || pend_r[0] || pend_r[1]), 0);
        #1;
    endtask

    vec_t vecs [7];
    op_t  o0, o1;
    int   b_g0, b_g1, b_r0, b_r1, b_w, b_gc, b_gb, p, n, ng, last_c, got, w, mode;
    logic [DW-1:0] exp_rd [2];
    int   exp_order [4];
    int   n_rr, exp_g1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b1, 4'h3, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 4'hF, 8'h3C, 8'h00};
        vecs[3] = '{0, 1'b0, 4'hF, 8'h00, 8'h3C};
        vecs[4] = '{1, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[5] = '{0, 1'b1, 4'h0, 8'hFF, 8'h00};
        vecs[6] = '{1, 1'b0, 4'h0, 8'h00, 8'hFF};

        if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;

        // Power-on reset.
        #1 reset = 1'b1;
        #2;
        check("por busy", 32'(busy), 0);
        check("por gnt0", 32'(if0.gnt), 0);
        check("por gnt1", 32'(if1.gnt), 0);
        check("por ram_wen", 32'(ram_wen), 0);
        check("por ram_addr", 32'(ram_addr), 0);
        #19 reset = 1'b0;
        @(negedge clk);
        #1;

        // Directed table: single-port accesses.
        foreach (vecs[i]) begin
            b_g0 = n_gnt0; b_g1 = n_gnt1; b_r0 = n_rv0; b_r1 = n_rv1; b_w = n_wen;
            p = vecs[i].port;
            o0 = '{vecs[i].we, vecs[i].addr, vecs[i].wdata};
            run_ops(p == 0, o0, p == 1, o0);
            check($sformatf("vec%0d own gnt pulses", i), 32'(p == 0 ? n_gnt0 - b_g0 : n_gnt1 - b_g1), 1);
            check($sformatf("vec%0d other gnt pulses", i), 32'(p == 0 ? n_gnt1 - b_g1 : n_gnt0 - b_g0), 0);
            check($sformatf("vec%0d ram_wen cycles", i), 32'(n_wen - b_w), vecs[i].we ? 1 : 0);
            check($sformatf("vec%0d own rvalid", i), 32'(p == 0 ? n_rv0 - b_r0 : n_rv1 - b_r1), vecs[i].we ? 0 : 1);
            check($sformatf("vec%0d other rvalid", i), 32'(p == 0 ? n_rv1 - b_r1 : n_rv0 - b_r0), 0);
            if (!vecs[i].we) begin
                check($sformatf("vec%0d rdata", i), 32'(r_dat[p]), 32'(vecs[i].exp_rdata));
                check($sformatf("vec%0d rvalid after gnt", i), 32'(r_cyc[p] - g_cyc[p]), 2);
            end else begin
                exp_mem[vecs[i].addr] = vecs[i].wdata;
            end
            model_last = p;
        end

        // Reset in the middle of a port-0 read.
        b_r0 = n_rv0; b_r1 = n_rv1;
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 4'h3;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0.gnt && n < 10);
        check("midread gnt seen", 32'(if0.gnt), 1);
        if0.req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst gnt0", 32'(if0.gnt), 0);
        check("rst gnt1", 32'(if1.gnt), 0);
        check("rst rvalid0", 32'(if0.rvalid), 0);
        check("rst rvalid1", 32'(if1.rvalid), 0);
        check("rst rdata0", 32'(if0.rdata), 0);
        check("rst rdata1", 32'(if1.rdata), 0);
        check("rst ram_wen", 32'(ram_wen), 0);
        check("rst ram_addr", 32'(ram_addr), 0);
        check("rst ram_din", 32'(ram_din), 0);
        #14 reset = 1'b0;
        model_last = 1;
        repeat (6) @(negedge clk);
        #1;
        check("no rvalid after reset", 32'((n_rv0 - b_r0) + (n_rv1 - b_r1)), 0);
        check("busy low after reset", 32'(busy), 0);

        // Both ports hold write requests: grant order follows the model.
        n_rr = FIXED_PRIO ? 3 : 4;
        exp_g1 = 0;
        for (int i = 0; i < n_rr; i++) begin
            w = FIXED_PRIO ? 0 : 1 - model_last;
            exp_order[i] = w;
            exp_g1 += w;
            model_last = w;
        end
        b_g1 = n_gnt1;
        if0.req = 1'b1; if0.we = 1'b1; if0.addr = 4'h5; if0.wdata = 8'h11;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 4'h6; if1.wdata = 8'h22;
        ng = 0; n = 0; last_c = 0;
        while (ng < n_rr && n < 40) begin
            @(negedge clk);
            n++;
            if (if0.gnt || if1.gnt) begin
                got = if1.gnt ? 1 : 0;
                check($sformatf("arb order %0d", ng), 32'(got), 32'(exp_order[ng]));
                if (ng > 0) check($sformatf("arb gnt spacing %0d", ng), 32'(cyc - last_c), 2);
                last_c = cyc;
                ng++;
            end
        end
        if0.req = 1'b0;
        if1.req = 1'b0;
        check("arb grant count", 32'(ng), 32'(n_rr));
        #1;
        check("arb port1 grants", 32'(n_gnt1 - b_g1), 32'(exp_g1));
        exp_mem[5] = 8'h11;
        if (exp_g1 != 0) exp_mem[6] = 8'h22;
        repeat (2) @(negedge clk);
        #1;

        // Wrap and fill on port 1, back to back.
        for (int a = 0; a < 16; a++) begin
            o1 = '{1'b1, 4'(a), 8'(a * 2)};
            run_ops(1'b0, o1, 1'b1, o1);
            exp_mem[a] = 8'(a * 2);
            if (a == 0) begin
                b_gc = gap_cnt;
                b_gb = gap_bad;
            end
        end
        for (int a = 0; a < 16; a++) begin
            o1 = '{1'b0, 4'(a), 8'h00};
            run_ops(1'b0, o1, 1'b1, o1);
            check($sformatf("fill read addr %0d", a), 32'(r_dat[1]), 32'(a * 2));
        end
        model_last = 1;
        check("fill idle gaps counted", 32'(gap_cnt - b_gc), 31);
        check("fill idle gaps longer than 1", 32'(gap_bad - b_gb), 0);

        // Random traffic against the model.
        for (int it = 0; it < 80; it++) begin
            mode = $urandom_range(0, 2);
            o0 = '{1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom)};
            o1 = '{1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom)};
            if (mode == 2) w = FIXED_PRIO ? 0 : 1 - model_last;
            else           w = mode;
            for (int k = 0; k < (mode == 2 ? 2 : 1); k++) begin
                p = (k == 0) ? w : 1 - w;
                if (p == 0) begin
                    if (o0.we) exp_mem[o0.addr] = o0.data; else exp_rd[0] = exp_mem[o0.addr];
                end else begin
                    if (o1.we) exp_mem[o1.addr] = o1.data; else exp_rd[1] = exp_mem[o1.addr];
                end
                model_last = p;
            end
            run_ops(mode != 1, o0, mode != 0, o1);
            check($sformatf("rand%0d first winner", it), 32'(first_gnt), 32'(w));
            if (mode != 1 && !o0.we) check($sformatf("rand%0d rdata0", it), 32'(r_dat[0]), 32'(exp_rd[0]));
            if (mode != 0 && !o1.we) check($sformatf("rand%0d rdata1", it), 32'(r_dat[1]), 32'(exp_rd[1]));
        end

        check("gnt never on both ports", 32'(n_both_gnt), 0);
        check("rvalid never on both ports", 32'(n_both_rv), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
